// File: rtl/deinterleaver_pkg.sv
// Shared sizing helper, default geometry and read-FSM encoding for the block deinterleaver.
package deinterleaver_pkg;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(v)) w = w + 1;
    return w;
  endfunction

  localparam int unsigned ROW_NUMBER_DEF = 10;
  localparam int unsigned COL_NUMBER_DEF = 7;
  localparam int unsigned N_DEF          = ROW_NUMBER_DEF * COL_NUMBER_DEF;
  localparam int unsigned ADDR_W_DEF     = clog2_min1(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/deinterleaver_wr_addr_gen.sv
// Write-side address generator: walks a column-major input stream onto row-major
// storage addresses, flagging the final element of each block.
module deinterleaver_wr_addr_gen
  import deinterleaver_pkg::*;
#(
  parameter int unsigned ROW_NUMBER = ROW_NUMBER_DEF,
  parameter int unsigned COL_NUMBER = COL_NUMBER_DEF,
  parameter int unsigned ADDR_W     = clog2_min1(ROW_NUMBER * COL_NUMBER)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam int unsigned R_W = clog2_min1(ROW_NUMBER);
  localparam int unsigned C_W = clog2_min1(COL_NUMBER);
  localparam logic [R_W-1:0] R_LAST = R_W'(ROW_NUMBER - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(COL_NUMBER - 1);

  logic [R_W-1:0]    r_q, r_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_c = (r_q == R_LAST) && (c_q == C_LAST);
  assign addr   = addr_q;

  // Rows advance fastest; a column wrap restarts the accumulator at the next column.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    addr_d = addr_q;
    if (adv) begin
      if (last_c) begin
        r_d    = '0;
        c_d    = '0;
        addr_d = '0;
      end else if (r_q == R_LAST) begin
        r_d    = '0;
        c_d    = c_q + C_W'(1);
        addr_d = ADDR_W'(c_q) + ADDR_W'(1);
      end else begin
        r_d    = r_q + R_W'(1);
        addr_d = addr_q + ADDR_W'(COL_NUMBER);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver: fills one bank in column-major order while the
// other bank drains to the output FIFO in row-major order.
module deinterleaver
  import deinterleaver_pkg::*;
#(
  parameter int unsigned ROW_NUMBER = ROW_NUMBER_DEF,
  parameter int unsigned COL_NUMBER = COL_NUMBER_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic FIFO_IN_DATA,
  output logic FIFO_IN_RE,
  input  logic FIFO_IN_EMPTY,
  output logic FIFO_OUT_DATA,
  output logic FIFO_OUT_WE,
  input  logic FIFO_OUT_FULL
);

  localparam int unsigned N      = ROW_NUMBER * COL_NUMBER;
  localparam int unsigned ADDR_W = clog2_min1(N);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);

  logic              req_c;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last_c;

  logic              req_bank_q, req_bank_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic              pipe_bank_q, pipe_bank_d;
  logic              pipe_last_q, pipe_last_d;
  logic [1:0]        full_q, full_d;

  rd_state_e         state_q, state_d;
  logic              rd_issue_c, rd_done_c;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              we_q, we_d;
  logic              dout_q, dout_d;

  logic bank0_mem [N];
  logic bank1_mem [N];

  // Reset already freezes every flop, so the request term only gates the strobe.
  assign req_c         = !FIFO_IN_EMPTY && !full_q[req_bank_q];
  assign FIFO_IN_RE    = req_c && !RESET;
  assign FIFO_OUT_WE   = we_q;
  assign FIFO_OUT_DATA = dout_q;

  deinterleaver_wr_addr_gen #(
    .ROW_NUMBER (ROW_NUMBER),
    .COL_NUMBER (COL_NUMBER),
    .ADDR_W     (ADDR_W)
  ) u_wr_addr_gen (
    .clk    (CLK),
    .rst    (RESET),
    .adv    (req_c),
    .addr   (wr_addr),
    .last_c (wr_last_c)
  );

  // Request stage feeds the data stage one cycle later; set/clear of full never share a bank.
  always_comb begin
    req_bank_d  = req_bank_q;
    pipe_vld_d  = req_c;
    pipe_addr_d = wr_addr;
    pipe_bank_d = req_bank_q;
    pipe_last_d = wr_last_c;
    full_d      = full_q;
    if (req_c && wr_last_c) req_bank_d = ~req_bank_q;
    if (pipe_vld_q && pipe_last_q) full_d[pipe_bank_q] = 1'b1;
    if (rd_done_c) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (pipe_vld_q) begin
      if (pipe_bank_q) bank1_mem[pipe_addr_q] <= FIFO_IN_DATA;
      else             bank0_mem[pipe_addr_q] <= FIFO_IN_DATA;
    end
  end

  // Read FSM: state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Read FSM: next state. IDLE issues address 0 itself to save a cycle of latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (full_q[rd_bank_q] && !FIFO_OUT_FULL) state_d = READ;
      READ:    if (!FIFO_OUT_FULL && (rd_addr_q == ADDR_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM: outputs.
  always_comb begin
    rd_issue_c = 1'b0;
    rd_done_c  = 1'b0;
    unique case (state_q)
      IDLE:    rd_issue_c = full_q[rd_bank_q] && !FIFO_OUT_FULL;
      READ:    rd_issue_c = !FIFO_OUT_FULL;
      DONE:    rd_done_c  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    we_d      = rd_issue_c;
    dout_d    = dout_q;
    if (rd_issue_c) begin
      rd_addr_d = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_W'(1);
      dout_d    = rd_bank_q ? bank1_mem[rd_addr_q] : bank0_mem[rd_addr_q];
    end
    if (rd_done_c) rd_bank_d = ~rd_bank_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_bank_q  <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_bank_q <= 1'b0;
      pipe_last_q <= 1'b0;
      full_q      <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      we_q        <= 1'b0;
      dout_q      <= 1'b0;
    end else begin
      req_bank_q  <= req_bank_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_bank_q <= pipe_bank_d;
      pipe_last_q <= pipe_last_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      we_q        <= we_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Bench for deinterleaver: a 3x2 instance driven by directed blocks and a default
// 10x7 instance fed by a golden interleaver, both checked against queue models.
module tb_deinterleaver;

  localparam int R_S = 3;
  localparam int C_S = 2;
  localparam int N_S = R_S * C_S;
  localparam int R_L = 10;
  localparam int C_L = 7;
  localparam int N_L = R_L * C_L;
  localparam int BLOCKS_L = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic s_in_data = 1'b0, s_in_empty = 1'b1, s_out_full = 1'b0;
  logic s_in_re, s_out_data, s_out_we;
  logic l_in_data = 1'b0, l_in_empty = 1'b1, l_out_full = 1'b0;
  logic l_in_re, l_out_data, l_out_we;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  bit s_in_q[$], s_acc[$], s_exp[$], s_log[$];
  bit l_in_q[$], l_exp[$];
  bit s_re_seen = 1'b0, l_re_seen = 1'b0;
  bit s_prev_full = 1'b0, l_prev_full = 1'b0;
  int s_re_total = 0, s_re_run = 0, s_re_max = 0;
  int s_last_re_cyc = 0, s_first_we_cyc = -1;
  int l_we_count = 0;
  bit gold[N_L];

  deinterleaver #(.ROW_NUMBER(R_S), .COL_NUMBER(C_S)) dut_s (
    .CLK           (clk),
    .RESET         (rst),
    .FIFO_IN_DATA  (s_in_data),
    .FIFO_IN_RE    (s_in_re),
    .FIFO_IN_EMPTY (s_in_empty),
    .FIFO_OUT_DATA (s_out_data),
    .FIFO_OUT_WE   (s_out_we),
    .FIFO_OUT_FULL (s_out_full)
  );

  deinterleaver dut_l (
    .CLK           (clk),
    .RESET         (rst),
    .FIFO_IN_DATA  (l_in_data),
    .FIFO_IN_RE    (l_in_re),
    .FIFO_IN_EMPTY (l_in_empty),
    .FIFO_OUT_DATA (l_out_data),
    .FIFO_OUT_WE   (l_out_we),
    .FIFO_OUT_FULL (l_out_full)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Sample on the rising edge, before any DUT flop update becomes visible.
  always @(posedge clk) begin : cmp
    bit e;
    cyc++;
    s_re_seen = s_in_re;
    l_re_seen = l_in_re;
    if (s_in_re) begin
      s_re_total++;
      s_re_run++;
      s_last_re_cyc = cyc;
      if (s_re_run > s_re_max) s_re_max = s_re_run;
    end else begin
      s_re_run = 0;
    end
    if (rst) check(!s_out_we && !l_out_we, "we_in_reset", int'({s_out_we, l_out_we}), 0);
    if (s_out_we) begin
      check(!s_prev_full, "we_after_full_issue_s", int'(s_prev_full), 0);
      check(s_exp.size() != 0, "we_without_pending_bit_s", 1, s_exp.size());
      if (s_exp.size() != 0) begin
        e = s_exp.pop_front();
        check(s_out_data == e, "data_s", int'(s_out_data), int'(e));
      end
      s_log.push_back(s_out_data);
      if (s_first_we_cyc < 0) s_first_we_cyc = cyc;
    end
    if (l_out_we) begin
      l_we_count++;
      check(!l_prev_full, "we_after_full_issue_l", int'(l_prev_full), 0);
      check(l_exp.size() != 0, "we_without_pending_bit_l", 1, l_exp.size());
      if (l_exp.size() != 0) begin
        e = l_exp.pop_front();
        check(l_out_data == e, "data_l", int'(l_out_data), int'(e));
      end
    end
    s_prev_full = s_out_full;
    l_prev_full = l_out_full;
  end

  // Input FIFO models; the small instance's consumed bits are deinterleaved per block.
  always @(negedge clk) begin
    if (s_re_seen) begin
      check(s_in_q.size() != 0, "re_while_empty_s", 0, 1);
      if (s_in_q.size() != 0) begin
        s_in_data = s_in_q.pop_front();
        s_acc.push_back(s_in_data);
        if (s_acc.size() == N_S) begin
          // Output row-major position a holds the input sent at column-major index.
          for (int a = 0; a < N_S; a++) s_exp.push_back(s_acc[(a % C_S) * R_S + a / C_S]);
          s_acc.delete();
        end
      end
    end
    if (l_re_seen) begin
      check(l_in_q.size() != 0, "re_while_empty_l", 0, 1);
      if (l_in_q.size() != 0) l_in_data = l_in_q.pop_front();
    end
    s_in_empty = (s_in_q.size() == 0);
    l_in_empty = (l_in_q.size() == 0);
  end

  task automatic push_s(input bit blk[N_S]);
    for (int i = 0; i < N_S; i++) s_in_q.push_back(blk[i]);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((s_in_q.size() != 0 || s_exp.size() != 0 || l_in_q.size() != 0 ||
            l_exp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(n < budget, {name, "_drain_timeout"}, n, budget);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_log_s(input bit want[N_S], input string name);
    check(s_log.size() == N_S, {name, "_len"}, s_log.size(), N_S);
    for (int i = 0; i < N_S; i++)
      if (i < s_log.size()) check(s_log[i] == want[i], name, int'(s_log[i]), int'(want[i]));
  endtask

  initial begin
    bit blk[N_S];
    bit want[N_S];
    bit blk18[18];
    int i;

    repeat (3) @(negedge clk);
    check(!s_in_re && !s_out_we && !s_out_data, "reset_state_s",
          int'({s_in_re, s_out_we, s_out_data}), 0);
    check(!l_in_re && !l_out_we && !l_out_data, "reset_state_l",
          int'({l_in_re, l_out_we, l_out_data}), 0);
    rst = 1'b0;
    @(negedge clk);
    check(!s_in_re, "re_when_empty", int'(s_in_re), 0);

    // Single set bit at k=3 lands at row 0, column 1.
    s_log.delete();
    s_first_we_cyc = -1;
    blk = '{0, 0, 0, 1, 0, 0};
    push_s(blk);
    wait_drain(200, "t1");
    want = '{0, 1, 0, 0, 0, 0};
    check_log_s(want, "t1_out");
    // RE cycle, then write cycle, then WE two cycles after the write.
    check(s_first_we_cyc - s_last_re_cyc == 3, "t1_first_we_latency",
          s_first_we_cyc - s_last_re_cyc, 3);

    // k=0,2,4 land at addr 0,4,3.
    s_log.delete();
    blk = '{1, 0, 1, 0, 1, 0};
    push_s(blk);
    wait_drain(200, "t2");
    want = '{1, 0, 0, 1, 1, 0};
    check_log_s(want, "t2_out");

    // Three blocks with the output held full: both banks fill, then the writer stalls.
    s_log.delete();
    s_out_full = 1'b1;
    s_re_total = 0;
    s_re_run = 0;
    s_re_max = 0;
    blk18 = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0};
    for (int k = 0; k < 18; k++) s_in_q.push_back(blk18[k]);
    repeat (25) @(negedge clk);
    check(s_re_total == 12, "t3_re_count", s_re_total, 12);
    check(s_re_max == 12, "t3_re_contiguous", s_re_max, 12);
    check(s_log.size() == 0, "t3_no_output_while_full", s_log.size(), 0);
    s_out_full = 1'b0;
    wait_drain(300, "t3");
    check(s_log.size() == 18, "t3_out_count", s_log.size(), 18);

    // Output full toggling every cycle during two drains.
    s_log.delete();
    blk = '{0, 1, 1, 0, 1, 0};
    push_s(blk);
    blk = '{1, 0, 0, 1, 1, 1};
    push_s(blk);
    i = 0;
    while ((s_in_q.size() != 0 || s_exp.size() != 0 || s_acc.size() != 0) && i < 400) begin
      @(negedge clk);
      s_out_full = (i % 2 == 1);
      i++;
    end
    s_out_full = 1'b0;
    check(i < 400, "t4_drain_timeout", i, 400);
    wait_drain(200, "t4");
    check(s_log.size() == 12, "t4_out_count", s_log.size(), 12);
    check(s_out_data == 1'b1, "t4_last_bit", int'(s_out_data), 1);

    // Reset after a partial block; that block is discarded.
    blk = '{1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 4; k++) s_in_q.push_back(blk[k]);
    i = 0;
    while (s_in_q.size() != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s_acc.delete();
    s_exp.delete();
    repeat (3) begin
      @(negedge clk);
      check(!s_in_re && !s_out_we && !s_out_data, "t5_outputs_in_reset",
            int'({s_in_re, s_out_we, s_out_data}), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    s_log.delete();
    blk = '{1, 1, 0, 1, 0, 1};
    push_s(blk);
    wait_drain(200, "t5");
    want = '{1, 1, 1, 0, 0, 1};
    check_log_s(want, "t5_out");

    // Default geometry: random payloads pushed through a golden interleaver.
    l_we_count = 0;
    for (int b = 0; b < BLOCKS_L; b++) begin
      for (int k = 0; k < N_L; k++) begin
        gold[k] = 1'($urandom);
        l_exp.push_back(gold[k]);
      end
      for (int k = 0; k < N_L; k++) l_in_q.push_back(gold[(k % R_L) * C_L + k / R_L]);
    end
    wait_drain(20000, "t6");
    check(l_we_count == N_L * BLOCKS_L, "t6_out_count", l_we_count, N_L * BLOCKS_L);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
